// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry, address
// field positions and the controller state encoding.
package instr_cache_defs;

    localparam int WORD_SIZE_D   = 16;
    localparam int INDEX_BITS_D  = 3;
    localparam int OFFSET_BITS_D = 2;
    localparam int TAG_BITS_D    = WORD_SIZE_D - INDEX_BITS_D - OFFSET_BITS_D;

    localparam int LINE_WORDS = 1 << OFFSET_BITS_D;
    localparam int NUM_LINES  = 1 << INDEX_BITS_D;

    // Field positions within a word address: {tag, index, offset}
    localparam int OFFSET_LSB = 0;
    localparam int INDEX_LSB  = OFFSET_BITS_D;
    localparam int TAG_LSB    = OFFSET_BITS_D + INDEX_BITS_D;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Line storage: per-line valid bit, tag and data words. Only the valid bits
// are reset; tags and data are meaningless until their line is validated.
module icache_line_array #(
    parameter int WORD_SIZE   = 16,
    parameter int INDEX_BITS  = 3,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [INDEX_BITS-1:0]  rd_index,
    input  logic [OFFSET_BITS-1:0] rd_offset,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [WORD_SIZE-1:0]   rd_word,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_index,
    input  logic [OFFSET_BITS-1:0] wr_offset,
    input  logic [WORD_SIZE-1:0]   wr_data,
    input  logic                   set_en,
    input  logic [INDEX_BITS-1:0]  set_index,
    input  logic [TAG_BITS-1:0]    set_tag,
    input  logic                   clr_en,
    input  logic [INDEX_BITS-1:0]  clr_index
);

    localparam int NL = 1 << INDEX_BITS;
    localparam int LW = 1 << OFFSET_BITS;

    logic [NL-1:0]        valid;
    logic [TAG_BITS-1:0]  tags [NL];
    logic [WORD_SIZE-1:0] data [NL][LW];

    // Flush wins over any per-line update in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (clr_en) valid[clr_index] <= 1'b0;
            if (set_en) valid[set_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) tags[set_index] <= set_tag;
        if (wr_en)  data[wr_index][wr_offset] <= wr_data;
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_word  = data[rd_index][rd_offset];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line
// refill on a miss via sequential single-word memory reads.
module instr_cache
    import instr_cache_defs::*;
#(
    parameter int WORD_SIZE   = WORD_SIZE_D,
    parameter int INDEX_BITS  = INDEX_BITS_D,
    parameter int OFFSET_BITS = OFFSET_BITS_D
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 i_flush,
    output logic                 m_readM,
    output logic [WORD_SIZE-1:0] m_address,
    input  logic [WORD_SIZE-1:0] m_data,
    input  logic                 m_valid,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam logic [WORD_SIZE-1:0]   CNT_ONE  = 1;
    localparam logic [OFFSET_BITS-1:0] FILL_ONE = 1;

    logic [TAG_BITS-1:0]    a_tag;
    logic [INDEX_BITS-1:0]  a_index;
    logic [OFFSET_BITS-1:0] a_offset;
    assign {a_tag, a_index, a_offset} = i_address;

    state_t                 state, state_nx;
    logic [TAG_BITS-1:0]    lat_tag;
    logic [INDEX_BITS-1:0]  lat_index;
    logic [OFFSET_BITS-1:0] fill_cnt;

    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [WORD_SIZE-1:0]   rd_word;
    logic                   lookup_hit;
    logic                   flush_all, clr_en, wr_en, set_en;
    logic                   miss, hit_inc, fill_adv;

    icache_line_array #(
        .WORD_SIZE   (WORD_SIZE),
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_lines (
        .clk       (Clk),
        .rst_n     (Reset_N),
        .flush     (flush_all),
        .rd_index  (a_index),
        .rd_offset (a_offset),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (wr_en),
        .wr_index  (lat_index),
        .wr_offset (fill_cnt),
        .wr_data   (m_data),
        .set_en    (set_en),
        .set_index (lat_index),
        .set_tag   (lat_tag),
        .clr_en    (clr_en),
        .clr_index (a_index)
    );

    assign lookup_hit = rd_valid && (rd_tag == a_tag);

    always_comb begin
        state_nx  = state;
        flush_all = 1'b0;
        clr_en    = 1'b0;
        wr_en     = 1'b0;
        set_en    = 1'b0;
        miss      = 1'b0;
        hit_inc   = 1'b0;
        fill_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (i_flush) begin
                    flush_all = 1'b1;
                end else if (i_readM) begin
                    if (lookup_hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        miss     = 1'b1;
                        clr_en   = 1'b1;
                        state_nx = FILL;
                    end
                end
            end
            FILL: begin
                // An ack coinciding with the flush retires the only outstanding
                // request, so there is nothing left to drain.
                if (i_flush) begin
                    flush_all = 1'b1;
                    state_nx  = m_valid ? IDLE : DRAIN;
                end else if (m_valid) begin
                    wr_en    = 1'b1;
                    fill_adv = 1'b1;
                    if (fill_cnt == '1) begin
                        set_en   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (m_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign i_ready   = (state == IDLE) && i_readM && lookup_hit && !i_flush;
    assign i_data    = i_ready ? rd_word : '0;
    assign m_readM   = (state != IDLE);
    assign m_address = m_readM ? {lat_tag, lat_index, fill_cnt} : '0;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= IDLE;
            lat_tag    <= '0;
            lat_index  <= '0;
            fill_cnt   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nx;
            if (miss) begin
                lat_tag    <= a_tag;
                lat_index  <= a_index;
                fill_cnt   <= '0;
                miss_count <= miss_count + CNT_ONE;
            end
            if (fill_adv) fill_cnt  <= fill_cnt + FILL_ONE;
            if (hit_inc)  hit_count <= hit_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: table of fetches with hand-computed results
// plus sequences for flush and reset during a refill.
module tb_instr_cache;

    logic        Clk;
    logic        Reset_N;
    logic        i_readM;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        i_flush;
    logic        m_readM;
    logic [15:0] m_address;
    logic [15:0] m_data;
    logic        m_valid;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    instr_cache dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .i_readM    (i_readM),
        .i_address  (i_address),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .i_flush    (i_flush),
        .m_readM    (m_readM),
        .m_address  (m_address),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory: acknowledges in the mem_lat-th cycle of each request with
    // data = address + 0x100; tolerates requests that vanish mid-way.
    int          mem_lat = 2;
    int          mem_cnt = 0;
    logic [15:0] ack_log [$];

    always @(negedge Clk) begin
        if (!Reset_N || !m_readM) begin
            mem_cnt = 0;
            m_valid = 1'b0;
            m_data  = 16'h0000;
        end else begin
            mem_cnt = mem_cnt + 1;
            if (mem_cnt >= mem_lat) begin
                m_valid = 1'b1;
                m_data  = m_address + 16'h0100;
                ack_log.push_back(m_address);
                mem_cnt = 0;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One fetch held until it hits; on an expected miss also checks the stall
    // length and the refill address sequence.
    task automatic fetch(input logic [15:0] addr, input bit exp_miss, input logic [15:0] exp_data);
        int cyc;
        int base;
        logic [15:0] want;
        @(negedge Clk);
        i_readM   = 1'b1;
        i_address = addr;
        #1;
        if (exp_miss) begin
            check("miss_no_ready", 32'(i_ready), 32'd0);
            base = ack_log.size();
            cyc  = 0;
            while (!i_ready && cyc < 200) begin
                @(negedge Clk);
                #1;
                cyc++;
            end
            check("stall_cycles", 32'(cyc), 32'(4 * mem_lat + 1));
            check("refill_acks", 32'(ack_log.size() - base), 32'd4);
            for (int i = 0; i < 4; i++) begin
                if (base + i < ack_log.size()) begin
                    want = {addr[15:2], 2'(i)};
                    check("refill_addr", 32'(ack_log[base + i]), 32'(want));
                end
            end
        end
        check("hit_ready", 32'(i_ready), 32'd1);
        check("hit_data", 32'(i_data), 32'(exp_data));
    endtask

    task automatic idle_check(input logic [15:0] exp_hits, input logic [15:0] exp_misses);
        @(negedge Clk);
        i_readM   = 1'b0;
        i_address = 16'h0010;
        #1;
        check("idle_ready", 32'(i_ready), 32'd0);
        check("idle_data", 32'(i_data), 32'd0);
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_misses));
    endtask

    typedef struct {
        logic [15:0] addr;
        bit          miss;
        logic [15:0] data;
        bit          gap;
        logic [15:0] hits;
        logic [15:0] misses;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int cyc;
        vecs[0] = '{16'h0010, 1'b1, 16'h0110, 1'b1, 16'd1, 16'd1};
        vecs[1] = '{16'h0011, 1'b0, 16'h0111, 1'b0, 16'd0, 16'd0};
        vecs[2] = '{16'h0012, 1'b0, 16'h0112, 1'b0, 16'd0, 16'd0};
        vecs[3] = '{16'h0013, 1'b0, 16'h0113, 1'b1, 16'd4, 16'd1};
        vecs[4] = '{16'h0030, 1'b1, 16'h0130, 1'b1, 16'd5, 16'd2};
        vecs[5] = '{16'h0010, 1'b1, 16'h0110, 1'b1, 16'd6, 16'd3};
        vecs[6] = '{16'h0003, 1'b1, 16'h0103, 1'b1, 16'd7, 16'd4};
        vecs[7] = '{16'h0013, 1'b0, 16'h0113, 1'b1, 16'd8, 16'd4};
        vecs[8] = '{16'hFFFF, 1'b1, 16'h00FF, 1'b1, 16'd9, 16'd5};

        Reset_N   = 1'b0;
        i_readM   = 1'b0;
        i_address = 16'h0000;
        i_flush   = 1'b0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_ready", 32'(i_ready), 32'd0);
        check("rst_data", 32'(i_data), 32'd0);
        check("rst_mreadm", 32'(m_readM), 32'd0);
        check("rst_maddr", 32'(m_address), 32'd0);
        check("rst_hits", 32'(hit_count), 32'd0);
        check("rst_misses", 32'(miss_count), 32'd0);
        @(negedge Clk);
        Reset_N = 1'b1;

        foreach (vecs[k]) begin
            fetch(vecs[k].addr, vecs[k].miss, vecs[k].data);
            if (vecs[k].gap) idle_check(vecs[k].hits, vecs[k].misses);
        end

        // Flush in IDLE hides a hit and invalidates the cached line
        @(negedge Clk);
        i_readM   = 1'b1;
        i_address = 16'h0010;
        i_flush   = 1'b1;
        #1;
        check("flush_hides_ready", 32'(i_ready), 32'd0);
        check("flush_hides_data", 32'(i_data), 32'd0);
        @(negedge Clk);
        i_flush = 1'b0;
        i_readM = 1'b0;
        #1;
        check("flush_no_count_h", 32'(hit_count), 32'd9);
        check("flush_no_count_m", 32'(miss_count), 32'd5);
        fetch(16'h0010, 1'b1, 16'h0110);
        idle_check(16'd10, 16'd6);

        // Flush after the 2nd word of a refill: third request is drained
        mem_lat = 3;
        @(negedge Clk);
        i_readM   = 1'b1;
        i_address = 16'h0020;
        #1;
        check("mf_miss", 32'(i_ready), 32'd0);
        cyc = ack_log.size();
        @(negedge Clk);
        i_readM = 1'b0;
        while (ack_log.size() < cyc + 2 && ack_log.size() < cyc + 100) begin
            @(negedge Clk);
            if (m_readM == 1'b0) break;
        end
        check("mf_two_acks", 32'(ack_log.size() - cyc), 32'd2);
        @(negedge Clk);
        i_flush = 1'b1;
        #1;
        check("mf_third_addr", 32'(m_address), 32'h0022);
        @(negedge Clk);
        i_flush = 1'b0;
        #1;
        check("drain_readm", 32'(m_readM), 32'd1);
        begin
            int n = 0;
            while (m_readM && n < 20) begin
                check("drain_addr", 32'(m_address), 32'h0022);
                @(negedge Clk);
                #1;
                n++;
            end
        end
        check("drain_released", 32'(m_readM), 32'd0);
        check("drain_acks", 32'(ack_log.size() - cyc), 32'd3);
        check("mf_misses", 32'(miss_count), 32'd7);
        fetch(16'h0020, 1'b1, 16'h0120);
        idle_check(16'd11, 16'd8);

        // Asynchronous reset in the middle of a refill
        mem_lat = 2;
        @(negedge Clk);
        i_readM   = 1'b1;
        i_address = 16'h0040;
        @(negedge Clk);
        i_readM = 1'b0;
        @(negedge Clk);
        #1;
        check("rf_fill_active", 32'(m_readM), 32'd1);
        #2;
        Reset_N = 1'b0;
        #1;
        check("rf_mreadm", 32'(m_readM), 32'd0);
        check("rf_maddr", 32'(m_address), 32'd0);
        check("rf_hits", 32'(hit_count), 32'd0);
        check("rf_misses", 32'(miss_count), 32'd0);
        @(negedge Clk);
        Reset_N = 1'b1;
        fetch(16'h0020, 1'b1, 16'h0120);
        idle_check(16'd1, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the pipelined CPU's instruction-fetch port and the instruction memory. It serves hits in the same cycle as the fetch request. On a miss it stalls the fetch and refills a whole line with sequential single-word memory reads. It also supports a synchronous invalidate and keeps hit/miss counters for the testbench.

## Interface
- WORD_SIZE, 16: data and address width (word-addressed).
- INDEX_BITS, 3: line index width (8 lines).
- OFFSET_BITS, 2: word-in-line width (4 words/line); tag width = WORD_SIZE-INDEX_BITS-OFFSET_BITS.
- Clk  in  1  clock, all state changes on posedge.
- Reset_N  in  1  asynchronous, active-low reset.
- i_readM  in  1  CPU fetch request.
- i_address  in  WORD_SIZE  CPU fetch address.
- i_data  out  WORD_SIZE  fetched word; valid when i_ready=1.
- i_ready  out  1  hit: i_data valid this cycle.
- i_flush  in  1  invalidate all lines (single-cycle pulse).
- m_readM  out  1  memory read request.
- m_address  out  WORD_SIZE  memory word address.
- m_data  in  WORD_SIZE  memory read data.
- m_valid  in  1  m_data valid; acknowledges the current request.
- hit_count  out  WORD_SIZE  fetch hits since reset, wraps at 2^16.
- miss_count  out  WORD_SIZE  misses since reset, wraps at 2^16.

## Operation
- Address split: offset=[1:0], index=[4:2], tag=[15:5].
- Storage: per line a valid bit, a tag, and 4 data words. Reset clears all valid bits only; data and tags are don't-care.
- FSM states are IDLE, FILL and DRAIN. Reset state is IDLE.
- IDLE, i_readM=1, hit (valid && tag match):
  - i_ready=1.
  - i_data = stored word, combinational.
  - hit_count+1 each such cycle.
- IDLE, i_readM=1, miss:
  - i_ready=0.
  - Latch tag and index; fill_cnt←0; miss_count+1; go to FILL.
  - Clear the line's valid bit.
- IDLE, i_readM=0: i_ready=0 and i_data=0.
- FILL:
  - m_readM=1; m_address={latched tag, index, fill_cnt}; i_ready=0.
  - On m_valid: write m_data to word fill_cnt and increment fill_cnt.
  - On m_valid with fill_cnt=3: set valid, write tag, go to IDLE. The CPU's re-presented request then hits.
- FILL ignores changes to i_readM and i_address; the line is always completed.
- i_flush in IDLE: all valid bits clear at the next edge; i_ready=0 that cycle, even if a hit.
- i_flush in FILL:
  - All valid bits clear and the state goes to DRAIN.
  - m_readM stays high with the same m_address until m_valid. The returned data is discarded, then IDLE.
- i_flush in DRAIN: no additional effect.
- Flush priority: i_flush outranks hit/miss processing in the same cycle, and the counters do not increment in that cycle.
- Outputs at reset: i_ready=0, i_data=0, m_readM=0, m_address=0, hit_count=0, miss_count=0.

## Timing
- Hit latency is 0 cycles (combinational from registered arrays).
- Memory handshake:
  - One request outstanding.
  - The request is held until m_valid.
  - The address advances at the edge where m_valid is sampled.
  - m_readM may stay high back-to-back across words.
- With memory latency L (m_valid in the L-th cycle of a request, L≥1), the miss-to-hit stall is 1+4L cycles. The miss cycle is followed by 4L FILL cycles, then the IDLE hit.
- m_readM drops in the cycle after the 4th m_valid.
- m_valid in IDLE is ignored.
- Reset asserted mid-FILL or mid-DRAIN: immediate return to IDLE, all valid bits clear, m_readM=0. The memory model must tolerate an abandoned request.
- Counters wrap 0xFFFF→0x0000.

## Structure
- Shared package/header instr_cache_defs holds:
  - line geometry constants (LINE_WORDS=4, NUM_LINES=8);
  - state encodings IDLE=2'd0, FILL=2'd1, DRAIN=2'd2;
  - tag/index/offset field macros.
- One sub-module, icache_line_array: valid/tag/data storage with one combinational read port, one word-write port, a tag/valid-set port, and a flush-all input.
- FSM, counters and the memory port stay in the top.

## Test plan
- Cold miss:
  - Stimulus: fetch 0x0010, memory L=2 returning data=address+0x100.
  - Response: m_address steps 0x0010..0x0013; i_ready rises 9 cycles later with i_data=0x0110; miss_count=1.
- Line reuse: after the above, fetch 0x0011, 0x0012, 0x0013 back-to-back. Each gives i_ready=1 in the same cycle, data 0x0111..0x0113; hit_count=4 (including the replay of 0x0010).
- Conflict eviction:
  - Stimulus: fetch 0x0010, then 0x0030 (same index 4), then 0x0010.
  - Response: three misses, miss_count=3, each refill correct.
- Flush in IDLE: after 0x0010 is cached, pulse i_flush, then fetch 0x0010 → miss, refill, miss_count increments.
- Flush mid-FILL:
  - Stimulus: pulse i_flush after the 2nd m_valid of a fill.
  - Response: DRAIN holds the 3rd address until m_valid, m_readM then drops, and the next fetch of that line misses.
- Reset mid-FILL:
  - Stimulus: drop Reset_N asynchronously between edges.
  - Response: m_readM=0, counters=0 immediately, and the next fetch misses.
